// File: rtl/mmcm_drp_reconfig_ctrl.sv
// MMCM run-time reconfiguration sequencer: holds the MMCM in reset, applies a table of
// masked read-modify-write DRP accesses, releases reset and waits for lock.
module mmcm_drp_reconfig_ctrl #(
  parameter int TBL_AW       = 3,
  parameter int RST_SETTLE   = 8,
  parameter int DRP_TIMEOUT  = 255,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              tbl_we,
  input  logic [TBL_AW-1:0] tbl_addr,
  input  logic [6:0]        tbl_daddr,
  input  logic [15:0]       tbl_mask,
  input  logic [15:0]       tbl_data,
  input  logic [TBL_AW:0]   num_entries,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic              drp_den,
  output logic              drp_dwe,
  output logic [6:0]        drp_daddr,
  output logic [15:0]       drp_di,
  input  logic [15:0]       drp_do,
  input  logic              drp_drdy,
  output logic              mmcm_rst,
  input  logic              mmcm_locked
);
  localparam int DEPTH = 2**TBL_AW;
  localparam int MAX1  = (DRP_TIMEOUT > RST_SETTLE) ? DRP_TIMEOUT : RST_SETTLE;
  localparam int MAXC  = (LOCK_TIMEOUT > MAX1) ? LOCK_TIMEOUT : MAX1;
  localparam int CW    = $clog2(MAXC + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HOLD, S_RD, S_WAIT_RD, S_WR, S_WAIT_WR, S_RELEASE, S_WAIT_LOCK, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [TBL_AW:0]   num_q, num_d;
  logic [15:0]       rd_q, rd_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [1:0]        code_q, code_d;
  logic              lock_meta_q, lock_s_q;

  logic [6:0]  mem_daddr [DEPTH];
  logic [15:0] mem_mask  [DEPTH];
  logic [15:0] mem_data  [DEPTH];

  always_ff @(posedge sys_clk) begin
    if (tbl_we && !busy) begin
      mem_daddr[tbl_addr] <= tbl_daddr;
      mem_mask[tbl_addr]  <= tbl_mask;
      mem_data[tbl_addr]  <= tbl_data;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    num_d   = num_q;
    rd_d    = rd_q;
    done_d  = 1'b0;
    error_d = error_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: if (start) begin
        num_d   = num_entries;
        idx_d   = '0;
        cnt_d   = '0;
        error_d = 1'b0;
        code_d  = 2'd0;
        if (num_entries == '0) done_d = 1'b1;
        else                   state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == CW'(RST_SETTLE - 1)) begin
          cnt_d   = '0;
          state_d = S_RD;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_RD: begin
        cnt_d   = '0;
        state_d = S_WAIT_RD;
      end
      S_WAIT_RD: begin
        if (drp_drdy) begin
          rd_d    = drp_do;
          state_d = S_WR;
        end else if (cnt_q == CW'(DRP_TIMEOUT - 1)) begin
          error_d = 1'b1;
          code_d  = 2'd1;
          state_d = S_IDLE;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_WR: begin
        cnt_d   = '0;
        state_d = S_WAIT_WR;
      end
      S_WAIT_WR: begin
        if (drp_drdy) begin
          idx_d   = idx_q + TBL_AW'(1);
          state_d = ({1'b0, idx_q} == num_q - (TBL_AW+1)'(1)) ? S_RELEASE : S_RD;
        end else if (cnt_q == CW'(DRP_TIMEOUT - 1)) begin
          error_d = 1'b1;
          code_d  = 2'd1;
          state_d = S_IDLE;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_RELEASE: begin
        cnt_d   = '0;
        state_d = S_WAIT_LOCK;
      end
      // The first two cycles may still see a synchronised lock from before the reset.
      S_WAIT_LOCK: begin
        if (lock_s_q && cnt_q >= CW'(2)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          error_d = 1'b1;
          code_d  = 2'd2;
          state_d = S_IDLE;
        end else cnt_d = cnt_q + CW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      num_q       <= '0;
      rd_q        <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      code_q      <= 2'd0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      num_q       <= num_d;
      rd_q        <= rd_d;
      done_q      <= done_d;
      error_q     <= error_d;
      code_q      <= code_d;
      lock_meta_q <= mmcm_locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Outputs decode from registered state so a reset clears them all on the next cycle.
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign mmcm_rst  = (state_q == S_HOLD) || (state_q == S_RD) || (state_q == S_WAIT_RD) ||
                     (state_q == S_WR) || (state_q == S_WAIT_WR);
  assign drp_den   = (state_q == S_RD) || (state_q == S_WR);
  assign drp_dwe   = (state_q == S_WR);
  assign drp_daddr = drp_den ? mem_daddr[idx_q] : 7'd0;
  assign drp_di    = drp_dwe ? ((rd_q & mem_mask[idx_q]) | (mem_data[idx_q] & ~mem_mask[idx_q])) : 16'd0;
  assign done      = done_q;
  assign error     = error_q;
  assign err_code  = code_q;
endmodule

// File: tb/tb_mmcm_drp_reconfig_ctrl.sv
// Bench for mmcm_drp_reconfig_ctrl: cycle-stepped DRP/MMCM model, write scoreboard, one task per scenario.
module tb_mmcm_drp_reconfig_ctrl;
  localparam int AW = 3, RS = 8, DT = 15, LT = 200;

  logic        sys_clk = 1'b0, sys_rst = 1'b1;
  logic        tbl_we = 1'b0, start = 1'b0;
  logic [AW-1:0] tbl_addr = '0;
  logic [6:0]  tbl_daddr = '0;
  logic [15:0] tbl_mask = '0, tbl_data = '0;
  logic [AW:0] num_entries = '0;
  logic        busy, done, error, drp_den, drp_dwe, mmcm_rst;
  logic [1:0]  err_code;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do = 16'hDEAD;
  logic        drp_drdy = 1'b0, mmcm_locked = 1'b0;

  mmcm_drp_reconfig_ctrl #(.TBL_AW(AW), .RST_SETTLE(RS), .DRP_TIMEOUT(DT), .LOCK_TIMEOUT(LT)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_daddr(tbl_daddr), .tbl_mask(tbl_mask), .tbl_data(tbl_data), .num_entries(num_entries),
    .start(start), .busy(busy), .done(done), .error(error), .err_code(err_code),
    .drp_den(drp_den), .drp_dwe(drp_dwe), .drp_daddr(drp_daddr), .drp_di(drp_di),
    .drp_do(drp_do), .drp_drdy(drp_drdy), .mmcm_rst(mmcm_rst), .mmcm_locked(mmcm_locked));

  always #5 sys_clk = ~sys_clk;

  logic [30:0] outs;
  assign outs = {busy, done, error, err_code, drp_den, drp_dwe, drp_daddr, drp_di, mmcm_rst};

  typedef struct packed { logic [6:0] a; logic [15:0] d; } wr_t;
  wr_t        exp_wr[$], obs_wr[$];
  logic [6:0] exp_rd[$], obs_rd[$];

  logic [15:0] drp_mem [128];
  logic [6:0]  t_addr [8];
  logic [15:0] t_mask [8], t_data [8];

  int n_chk = 0, n_pass = 0;
  int cyc = 0, start_cyc, rst_rise_cyc, rel_cyc, err_cyc, done_cyc, rd_den_cyc, wr_den_cyc;
  int n_den, n_rd, n_wr, n_done, n_rst_hi, n_busy, overlap, acc_n, due;
  int fixed_lat = 2, drop_rd = 0, lock_dly = 100;
  bit lat_var = 0, lock_en = 1, pend = 0, prev_rst = 0, prev_err = 0, busy_at_done;
  logic [15:0] pend_do;

  // One clock step: outputs are sampled 1ns after the edge, then the DRP/lock models drive inputs.
  task automatic tick();
    @(posedge sys_clk); #1; cyc++;
    start = 1'b0; tbl_we = 1'b0;
    if (drp_den) begin
      n_den++; acc_n++;
      if (pend) overlap++;
      if (drp_dwe) begin
        obs_wr.push_back(wr_t'{drp_daddr, drp_di}); drp_mem[drp_daddr] = drp_di;
        n_wr++; wr_den_cyc = cyc; pend_do = 16'h0;
      end else begin
        obs_rd.push_back(drp_daddr); n_rd++; rd_den_cyc = cyc; pend_do = drp_mem[drp_daddr];
      end
      if (drp_dwe || n_rd != drop_rd) begin
        pend = 1; due = cyc + (lat_var ? 1 + (acc_n % 5) : fixed_lat);
      end
    end
    drp_drdy = 1'b0; drp_do = 16'hDEAD;
    if (pend && cyc == due) begin drp_drdy = 1'b1; drp_do = pend_do; pend = 0; end
    if (prev_rst && !mmcm_rst) rel_cyc = cyc;
    if (!prev_rst && mmcm_rst) begin rst_rise_cyc = cyc; rel_cyc = -1; end
    if (mmcm_rst) n_rst_hi++;
    if (busy) n_busy++;
    prev_rst = mmcm_rst;
    mmcm_locked = lock_en && !mmcm_rst && rel_cyc >= 0 && cyc >= rel_cyc + lock_dly;
    if (done) begin n_done++; done_cyc = cyc; busy_at_done = busy; end
    if (error && !prev_err) err_cyc = cyc;
    prev_err = error;
  endtask

  task automatic reset_counters();
    exp_wr.delete(); obs_wr.delete(); exp_rd.delete(); obs_rd.delete();
    n_den = 0; n_rd = 0; n_wr = 0; n_done = 0; n_rst_hi = 0; n_busy = 0; overlap = 0; acc_n = 0;
    err_cyc = -1; done_cyc = -1; rd_den_cyc = -1; wr_den_cyc = -1; rst_rise_cyc = -1;
  endtask

  task automatic write_tbl(input int i, input logic [6:0] a, input logic [15:0] m, input logic [15:0] d);
    tbl_addr = AW'(i); tbl_daddr = a; tbl_mask = m; tbl_data = d; tbl_we = 1'b1;
    t_addr[i] = a; t_mask[i] = m; t_data[i] = d;
    tick();
  endtask

  // Expected reads/writes from the shadow table applied in order to a copy of the DRP memory.
  task automatic push_exp(input int n);
    logic [15:0] m [128];
    logic [15:0] d;
    m = drp_mem;
    for (int e = 0; e < n; e++) begin
      exp_rd.push_back(t_addr[e]);
      d = (m[t_addr[e]] & t_mask[e]) | (t_data[e] & ~t_mask[e]);
      m[t_addr[e]] = d;
      exp_wr.push_back(wr_t'{t_addr[e], d});
    end
  endtask

  task automatic do_start(input int ne);
    num_entries = (AW+1)'(ne); start = 1'b1; start_cyc = cyc;
    tick();
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (n_done > 0 || err_cyc > start_cyc) begin ok = 1; break; end
      tick();
    end
    repeat (10) tick();
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) tick();
    n_chk++; if (outs !== 31'd0) $display("FAIL reset_outputs: got %h want 0", outs); else n_pass++;
    sys_rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    lat_var = 0; fixed_lat = 2; lock_en = 1; lock_dly = 100;
    drp_mem[8] = 16'hFFFF;
    write_tbl(0, 7'h08, 16'h1000, 16'h0145);
    reset_counters(); push_exp(1);
    do_start(1);
    wait_end(400, ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL single_timeout: got %0d want 1", ok); else n_pass++;
    n_chk++; if (rst_rise_cyc != start_cyc + 1) $display("FAIL single_rst_rise: got %0d want %0d", rst_rise_cyc, start_cyc + 1); else n_pass++;
    n_chk++; if (rd_den_cyc != start_cyc + 1 + RS) $display("FAIL single_rd_den: got %0d want %0d", rd_den_cyc, start_cyc + 1 + RS); else n_pass++;
    n_chk++; if (wr_den_cyc != rd_den_cyc + 3) $display("FAIL single_wr_den: got %0d want %0d", wr_den_cyc, rd_den_cyc + 3); else n_pass++;
    n_chk++; if (rel_cyc != wr_den_cyc + 3) $display("FAIL single_rst_fall: got %0d want %0d", rel_cyc, wr_den_cyc + 3); else n_pass++;
    n_chk++; if (n_rst_hi != rel_cyc - start_cyc - 1) $display("FAIL single_rst_width: got %0d want %0d", n_rst_hi, rel_cyc - start_cyc - 1); else n_pass++;
    n_chk++; if (done_cyc != rel_cyc + 103) $display("FAIL single_done_cyc: got %0d want %0d", done_cyc, rel_cyc + 103); else n_pass++;
    n_chk++; if (n_done != 1 || busy_at_done !== 1'b0) $display("FAIL single_done: got n=%0d busy=%0b want n=1 busy=0", n_done, busy_at_done); else n_pass++;
    n_chk++; if ({busy, error, err_code} !== 4'b0) $display("FAIL single_status: got %b want 0000", {busy, error, err_code}); else n_pass++;
    while (exp_wr.size() > 0) begin
      wr_t e = exp_wr.pop_front();
      wr_t o = (obs_wr.size() > 0) ? obs_wr.pop_front() : '1;
      n_chk++; if (o !== e) $display("FAIL single_write: got %h/%h want %h/%h", o.a, o.d, e.a, e.d); else n_pass++;
    end
    n_chk++; if (obs_wr.size() != 0 || n_rd != 1) $display("FAIL single_extra: got %0d writes %0d reads want 0/1", obs_wr.size(), n_rd); else n_pass++;
  endtask

  task automatic test_multi();
    bit ok;
    logic [6:0] a [4] = '{7'h10, 7'h11, 7'h28, 7'h4F};
    lat_var = 1; lock_en = 1; lock_dly = 20;
    for (int i = 0; i < 4; i++) begin
      drp_mem[a[i]] = 16'($urandom);
      write_tbl(i, a[i], 16'($urandom), 16'($urandom));
    end
    reset_counters(); push_exp(4);
    do_start(4);
    repeat (3) tick();
    num_entries = 4'd1; start = 1'b1;
    tbl_addr = 3'd3; tbl_daddr = 7'h7F; tbl_mask = 16'h0000; tbl_data = 16'hBAD0; tbl_we = 1'b1;
    tick();
    wait_end(600, ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL multi_timeout: got %0d want 1", ok); else n_pass++;
    while (exp_rd.size() > 0) begin
      logic [6:0] e = exp_rd.pop_front();
      logic [6:0] o = (obs_rd.size() > 0) ? obs_rd.pop_front() : 7'h7F;
      n_chk++; if (o !== e) $display("FAIL multi_read_addr: got %h want %h", o, e); else n_pass++;
    end
    while (exp_wr.size() > 0) begin
      wr_t e = exp_wr.pop_front();
      wr_t o = (obs_wr.size() > 0) ? obs_wr.pop_front() : '1;
      n_chk++; if (o !== e) $display("FAIL multi_write: got %h/%h want %h/%h", o.a, o.d, e.a, e.d); else n_pass++;
    end
    n_chk++; if (n_rd != 4 || n_wr != 4 || n_done != 1) $display("FAIL multi_counts: got rd=%0d wr=%0d done=%0d want 4/4/1", n_rd, n_wr, n_done); else n_pass++;
    n_chk++; if (overlap != 0) $display("FAIL multi_overlap: got %0d want 0", overlap); else n_pass++;
  endtask

  task automatic test_zero();
    bit ok;
    reset_counters();
    do_start(0);
    wait_end(20, ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL zero_timeout: got %0d want 1", ok); else n_pass++;
    n_chk++; if (done_cyc != start_cyc + 1) $display("FAIL zero_done_cyc: got %0d want %0d", done_cyc, start_cyc + 1); else n_pass++;
    n_chk++; if (n_den != 0 || n_rst_hi != 0 || n_busy != 0) $display("FAIL zero_activity: got den=%0d rst=%0d busy=%0d want 0", n_den, n_rst_hi, n_busy); else n_pass++;
    n_chk++; if (n_done != 1 || error !== 1'b0) $display("FAIL zero_done: got n=%0d err=%0b want 1/0", n_done, error); else n_pass++;
  endtask

  task automatic test_drp_timeout();
    bit ok;
    lat_var = 0; fixed_lat = 2; drop_rd = 2;
    write_tbl(0, 7'h20, 16'hFF00, 16'h0012);
    write_tbl(1, 7'h21, 16'h00FF, 16'h3400);
    reset_counters();
    do_start(2);
    wait_end(200, ok);
    repeat (20) tick();
    n_chk++; if (ok !== 1'b1) $display("FAIL drpto_timeout: got %0d want 1", ok); else n_pass++;
    n_chk++; if (err_cyc != rd_den_cyc + 16) $display("FAIL drpto_err_cyc: got %0d want %0d", err_cyc, rd_den_cyc + 16); else n_pass++;
    n_chk++; if ({error, err_code} !== 3'b101) $display("FAIL drpto_code: got %b want 101", {error, err_code}); else n_pass++;
    n_chk++; if (rel_cyc != err_cyc || mmcm_rst !== 1'b0) $display("FAIL drpto_rst: got fall=%0d rst=%0b want %0d/0", rel_cyc, mmcm_rst, err_cyc); else n_pass++;
    n_chk++; if (n_rd != 2 || n_wr != 1 || n_done != 0) $display("FAIL drpto_counts: got rd=%0d wr=%0d done=%0d want 2/1/0", n_rd, n_wr, n_done); else n_pass++;
    drop_rd = 0;
  endtask

  task automatic test_lock_timeout();
    bit ok;
    lock_en = 0; lat_var = 0; fixed_lat = 3;
    write_tbl(0, 7'h0A, 16'hF0F0, 16'h0A0A);
    reset_counters();
    do_start(1);
    wait_end(600, ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL lockto_timeout: got %0d want 1", ok); else n_pass++;
    n_chk++; if (err_cyc != rel_cyc + 1 + LT) $display("FAIL lockto_err_cyc: got %0d want %0d", err_cyc, rel_cyc + 1 + LT); else n_pass++;
    n_chk++; if ({error, err_code, mmcm_rst, busy} !== 5'b11000) $display("FAIL lockto_code: got %b want 11000", {error, err_code, mmcm_rst, busy}); else n_pass++;
    lock_en = 1; lock_dly = 30;
    reset_counters(); push_exp(1);
    do_start(1);
    n_chk++; if ({error, err_code} !== 3'b000) $display("FAIL lockto_clear: got %b want 000", {error, err_code}); else n_pass++;
    wait_end(600, ok);
    n_chk++; if (ok !== 1'b1 || n_done != 1 || error !== 1'b0) $display("FAIL lockto_rerun: got ok=%0d done=%0d err=%0b want 1/1/0", ok, n_done, error); else n_pass++;
    while (exp_wr.size() > 0) begin
      wr_t e = exp_wr.pop_front();
      wr_t o = (obs_wr.size() > 0) ? obs_wr.pop_front() : '1;
      n_chk++; if (o !== e) $display("FAIL lockto_write: got %h/%h want %h/%h", o.a, o.d, e.a, e.d); else n_pass++;
    end
  endtask

  task automatic test_sys_rst();
    bit ok;
    int guard = 0;
    lat_var = 0; fixed_lat = 4; lock_en = 1; lock_dly = 15;
    write_tbl(0, 7'h30, 16'h0F0F, 16'h1234);
    write_tbl(1, 7'h31, 16'hFFF0, 16'h000C);
    reset_counters();
    do_start(2);
    while (n_wr == 0 && guard < 100) begin tick(); guard++; end
    n_chk++; if (n_wr != 1) $display("FAIL rst_reach_write: got %0d writes want 1", n_wr); else n_pass++;
    tick();
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    n_chk++; if (outs !== 31'd0) $display("FAIL rst_mid_outputs: got %h want 0", outs); else n_pass++;
    repeat (8) tick();
    n_chk++; if (busy !== 1'b0 || n_wr != 1) $display("FAIL rst_idle: got busy=%0b wr=%0d want 0/1", busy, n_wr); else n_pass++;
    reset_counters(); push_exp(2);
    do_start(2);
    wait_end(400, ok);
    n_chk++; if (ok !== 1'b1 || n_done != 1 || error !== 1'b0) $display("FAIL rst_rerun: got ok=%0d done=%0d err=%0b want 1/1/0", ok, n_done, error); else n_pass++;
    while (exp_wr.size() > 0) begin
      wr_t e = exp_wr.pop_front();
      wr_t o = (obs_wr.size() > 0) ? obs_wr.pop_front() : '1;
      n_chk++; if (o !== e) $display("FAIL rst_write: got %h/%h want %h/%h", o.a, o.d, e.a, e.d); else n_pass++;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) drp_mem[i] = 16'($urandom);
    rel_cyc = -1;
    reset_counters();
    test_reset();
    test_single();
    test_multi();
    test_zero();
    test_drp_timeout();
    test_lock_timeout();
    test_sys_rst();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
